vend_fsm: RTL and testbench
===========================

// Module: vend_fsm
// PURPOSE
//   Vending control FSM, directly downstream of the keypad scanner and 4-bit debouncer.
//   Consumes one debounced key event per press and tracks product selection, coin credit,
//   per-product stock, dispense and change.
//   Its outputs feed the BCD/seven-segment display path and the dispense/change actuators.
// PARAMETERS
//   N_PRODUCTS      4           number of selectable products (key codes 0x1..N_PRODUCTS)
//   INIT_STOCK      5           stock loaded for every product at reset (4-bit counter)
//   MAX_CREDIT      99          credit ceiling; fits two BCD display digits
//   TIMEOUT_CYCLES  50_000_000  PAY inactivity limit (only with VEND_TIMEOUT_EN)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   reset        in   1  synchronous, active-high; one clock, synchronous active-high reset
//   key_valid    in   1  one-cycle pulse per debounced key press
//   key_code     in   4  key value, sampled when key_valid=1
//   product_id   out  2  selected product index (key code - 1)
//   price        out  8  price of selected product, binary
//   credit       out  8  accumulated credit, binary
//   change       out  8  change amount, valid with change_valid
//   dispense     out  1  high exactly one cycle per vend
//   change_valid out  1  one-cycle pulse; change holds its value until the next CHANGE
//   coin_reject  out  1  one-cycle pulse when a coin key is refused
//   sold_out     out  1  high while in SOLDOUT
//   state_o      out  3  current state encoding, for display and debug
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; all stock counters=INIT_STOCK.
//   Reset mid-operation: credit is discarded; no change pulse is issued.
//   All outputs are registered. key_valid is ignored when key_code is unmapped.
//   Key map:
//     0x1..0x4 select product
//     0xA coin 2; 0xB coin 5; 0xC coin 10
//     0xD cancel; 0xE product taken
//   IDLE:
//     select with stock>0 -> PAY; product_id/price loaded; credit=0.
//     select with stock=0 -> SOLDOUT.
//     coin -> coin_reject, no state change. Other keys ignored.
//   SOLDOUT: sold_out=1; any valid key -> IDLE (that key is consumed).
//   PAY:
//     coin accepted: credit+coin <= MAX_CREDIT -> credit updated at the next edge.
//     coin refused: otherwise -> coin_reject pulse, credit unchanged.
//     credit >= price -> DISPENSE on the following edge. Coin at cycle N: credit at N+1,
//       dispense high at N+2.
//     cancel -> CHANGE with change=credit. Select keys are ignored.
//   DISPENSE (1 cycle): dispense=1; stock[product_id] decremented (never wraps below 0);
//     change=credit-price latched -> WAIT_TAKE.
//   WAIT_TAKE: key 0xE -> CHANGE. Coins -> coin_reject. Other keys ignored.
//   CHANGE (1 cycle): change_valid=1; credit cleared -> IDLE. Change of 0 still pulses.
//   Arithmetic: 8-bit unsigned. The 9-bit sum is compared against MAX_CREDIT; no wrap.
//   Price table (package constant): product 0..3 = 15, 20, 25, 40.
// CONFIGURATION
//   VEND_TIMEOUT_EN defined:
//     an inactivity counter runs in PAY and resets on every valid key.
//     At TIMEOUT_CYCLES it acts as cancel (-> CHANGE, change=credit).
//   VEND_TIMEOUT_EN undefined: no counter is present; PAY waits indefinitely.
// STRUCTURE
//   Package vend_pkg:
//     state localparams: IDLE, PAY, DISPENSE, WAIT_TAKE, CHANGE, SOLDOUT
//     key code constants; coin value constants; price table
//   Sub-module vend_stock:
//     N_PRODUCTS 4-bit counters
//     decrement strobe plus index input
//     per-product empty flags; reload on reset
//   vend_fsm holds the state register, credit/change datapath and the optional timeout.
// TESTING
//   1. Select 0x1, then coins 0xC, 0xB -> credit 10, 15; dispense at +2 cycles;
//      after 0xE, change_valid with change=0.
//   2. Select 0x4 (price 40), coins 0xC x5 -> credit 50; dispense; 0xE -> change=10.
//   3. Credit 95, coin 0xB -> coin_reject pulse, credit stays 95.
//   4. Select 0x2, coin 0xA, cancel 0xD -> change_valid, change=2, state IDLE, no dispense.
//   5. Vend product 0x3 five times, select 0x3 again -> SOLDOUT, sold_out=1;
//      any key -> IDLE.
//   6. Reset asserted in PAY with credit 10 -> next cycle IDLE, credit 0, stock restored,
//      no change_valid. With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=100 and credit 5 ->
//      change=5 after 100 idle cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
//   Shared types and constants for the vending controller: FSM state
//   encoding (also driven out on state_o), keypad codes, coin values and the
//   product price table.
//   Optional feature macro used by vend_fsm: VEND_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package vend_pkg;

    localparam int STOCK_W = 4;   // per-product stock counter width
    localparam int MONEY_W = 8;   // credit / price / change width

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAY       = 3'd1,
        DISPENSE  = 3'd2,
        WAIT_TAKE = 3'd3,
        CHANGE    = 3'd4,
        SOLDOUT   = 3'd5
    } vend_state_e;

    // Keypad codes (product keys are 0x1..N_PRODUCTS)
    localparam logic [3:0] KEY_COIN2  = 4'hA;
    localparam logic [3:0] KEY_COIN5  = 4'hB;
    localparam logic [3:0] KEY_COIN10 = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;
    localparam logic [3:0] KEY_TAKE   = 4'hE;

    localparam logic [MONEY_W-1:0] COIN2_VAL  = 8'd2;
    localparam logic [MONEY_W-1:0] COIN5_VAL  = 8'd5;
    localparam logic [MONEY_W-1:0] COIN10_VAL = 8'd10;

    localparam logic [MONEY_W-1:0] PRICE_P0 = 8'd15;
    localparam logic [MONEY_W-1:0] PRICE_P1 = 8'd20;
    localparam logic [MONEY_W-1:0] PRICE_P2 = 8'd25;
    localparam logic [MONEY_W-1:0] PRICE_P3 = 8'd40;

    function automatic logic [MONEY_W-1:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = PRICE_P0;
            2'd1:    price_of = PRICE_P1;
            2'd2:    price_of = PRICE_P2;
            default: price_of = PRICE_P3;
        endcase
    endfunction

    // Value of a coin key; 0 for any key that is not a coin.
    function automatic logic [MONEY_W-1:0] coin_value(input logic [3:0] code);
        case (code)
            KEY_COIN2:  coin_value = COIN2_VAL;
            KEY_COIN5:  coin_value = COIN5_VAL;
            KEY_COIN10: coin_value = COIN10_VAL;
            default:    coin_value = '0;
        endcase
    endfunction

    function automatic logic is_coin(input logic [3:0] code);
        is_coin = (code == KEY_COIN2) || (code == KEY_COIN5) || (code == KEY_COIN10);
    endfunction

endpackage

// File: rtl/vend_stock.sv
// ---------------------------------------------------------------------------
// vend_stock
//   Per-product stock counters. Every counter loads INIT_STOCK on reset and
//   decrements by one on i_dec for product i_idx, saturating at zero.
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset (reloads all counters)
//   i_dec    in   decrement strobe, one cycle per vend
//   i_idx    in   product index to decrement
//   o_empty  out  per-product flag, 1 when that product's stock is zero
// ---------------------------------------------------------------------------
module vend_stock
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS = 4,
    parameter int INIT_STOCK = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_dec,
    input  logic [1:0]            i_idx,
    output logic [N_PRODUCTS-1:0] o_empty
);

    logic [STOCK_W-1:0] r_stock [N_PRODUCTS];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values no matter how the always blocks are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this small counter array is reset on purpose -- stock must
            // be known after reset -- unlike a RAM, which would stay unreset.
            for (int i = 0; i < N_PRODUCTS; i++) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else if (i_dec && (r_stock[i_idx] != '0)) begin
            r_stock[i_idx] <= r_stock[i_idx] - STOCK_W'(1);
        end
    end

    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_empty
        assign o_empty[g] = (r_stock[g] == '0);
    end

endmodule

// File: rtl/vend_fsm.sv
// ---------------------------------------------------------------------------
// vend_fsm
//   Vending control FSM fed by debounced key events. Tracks selection,
//   coin credit, per-product stock (vend_stock), dispense and change.
//   All outputs are registered.
// Ports
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   key_valid     in   one-cycle pulse per debounced key press
//   key_code[3:0] in   key value, sampled with key_valid
//   product_id    out  selected product index (key code - 1)
//   price         out  price of the selected product
//   credit        out  accumulated credit
//   change        out  change amount, updated together with change_valid
//   dispense      out  one-cycle vend strobe
//   change_valid  out  one-cycle change strobe
//   coin_reject   out  one-cycle pulse when a coin is refused
//   sold_out      out  high while in SOLDOUT
//   state_o       out  current state encoding (vend_pkg::vend_state_e)
// Configuration
//   VEND_TIMEOUT_EN : adds a PAY inactivity counter; after TIMEOUT_CYCLES
//                     cycles without a valid key it acts as cancel.
// ---------------------------------------------------------------------------
module vend_fsm
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS = 4,
    parameter int INIT_STOCK = 5,
    parameter int MAX_CREDIT = 99
`ifdef VEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] product_id,
    output logic [7:0] price,
    output logic [7:0] credit,
    output logic [7:0] change,
    output logic       dispense,
    output logic       change_valid,
    output logic       coin_reject,
    output logic       sold_out,
    output logic [2:0] state_o
);

    vend_state_e          r_state, w_next_state;
    logic [1:0]           r_product_id, w_product_id;
    logic [MONEY_W-1:0]   r_price, w_price;
    logic [MONEY_W-1:0]   r_credit, w_credit;
    logic [MONEY_W-1:0]   r_change, w_change;
    logic [MONEY_W-1:0]   r_change_due, w_change_due;
    logic                 r_dispense, r_change_valid, r_coin_reject, r_sold_out;
    logic                 w_coin_reject, w_stock_dec, w_timeout;
    logic                 w_key_sel, w_key_coin, w_key_cancel, w_key_take, w_key_any;
    logic [1:0]           w_sel_idx;
    logic [MONEY_W-1:0]   w_coin_val;
    logic [MONEY_W:0]     w_sum;
    logic                 w_coin_ok;
    logic [N_PRODUCTS-1:0] w_empty;

    // Key decode; unmapped codes never qualify as a key.
    assign w_key_sel    = key_valid && (key_code >= 4'd1) && (key_code <= 4'(N_PRODUCTS));
    assign w_key_coin   = key_valid && is_coin(key_code);
    assign w_key_cancel = key_valid && (key_code == KEY_CANCEL);
    assign w_key_take   = key_valid && (key_code == KEY_TAKE);
    assign w_key_any    = w_key_sel || w_key_coin || w_key_cancel || w_key_take;
    assign w_sel_idx    = 2'(key_code - 4'd1);

    // 9-bit sum so a coin near the ceiling cannot wrap past the check.
    assign w_coin_val = coin_value(key_code);
    assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok  = (w_sum <= 9'(MAX_CREDIT));

    vend_stock #(
        .N_PRODUCTS (N_PRODUCTS),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .i_dec   (w_stock_dec),
        .i_idx   (r_product_id),
        .o_empty (w_empty)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_idle_cnt;

    // Counts consecutive key-free cycles spent in PAY.
    always_ff @(posedge clk) begin
        if (reset || (r_state != PAY) || w_key_any) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == PAY) && !w_key_any &&
                       (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_next_state  = r_state;
        w_product_id  = r_product_id;
        w_price       = r_price;
        w_credit      = r_credit;
        w_change      = r_change;
        w_change_due  = r_change_due;
        w_coin_reject = 1'b0;
        w_stock_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key_sel) begin
                    if (w_empty[w_sel_idx]) begin
                        w_next_state = SOLDOUT;
                    end else begin
                        w_next_state = PAY;
                        w_product_id = w_sel_idx;
                        w_price      = price_of(w_sel_idx);
                        w_credit     = '0;
                    end
                end else if (w_key_coin) begin
                    w_coin_reject = 1'b1;
                end
            end
            PAY: begin
                // A coin arriving in the cycle the vend is decided is still
                // banked, so back-to-back coins are never silently dropped.
                if (w_key_coin) begin
                    if (w_coin_ok) begin
                        w_credit = w_sum[MONEY_W-1:0];
                    end else begin
                        w_coin_reject = 1'b1;
                    end
                end
                if (r_credit >= r_price) begin
                    w_next_state = DISPENSE;
                end else if (w_key_cancel || w_timeout) begin
                    w_next_state = CHANGE;
                    w_change     = r_credit;
                end
            end
            DISPENSE: begin
                w_stock_dec  = 1'b1;
                w_change_due = r_credit - r_price;
                w_next_state = WAIT_TAKE;
            end
            WAIT_TAKE: begin
                if (w_key_take) begin
                    w_next_state = CHANGE;
                    w_change     = r_change_due;
                end else if (w_key_coin) begin
                    w_coin_reject = 1'b1;
                end
            end
            CHANGE: begin
                w_credit     = '0;
                w_next_state = IDLE;
            end
            SOLDOUT: begin
                if (w_key_any) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with state_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_product_id   <= '0;
            r_price        <= '0;
            r_credit       <= '0;
            r_change       <= '0;
            r_change_due   <= '0;
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sold_out     <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_product_id   <= w_product_id;
            r_price        <= w_price;
            r_credit       <= w_credit;
            r_change       <= w_change;
            r_change_due   <= w_change_due;
            r_dispense     <= (w_next_state == DISPENSE);
            r_change_valid <= (w_next_state == CHANGE);
            r_coin_reject  <= w_coin_reject;
            r_sold_out     <= (w_next_state == SOLDOUT);
        end
    end

    assign product_id   = r_product_id;
    assign price        = r_price;
    assign credit       = r_credit;
    assign change       = r_change;
    assign dispense     = r_dispense;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;
    assign sold_out     = r_sold_out;
    assign state_o      = r_state;

endmodule

// File: tb/tb_vend_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_fsm
//   Self-checking bench for vend_fsm: directed scenarios with literal
//   expectations, then random key traffic compared every cycle against a
//   behavioural model of the vending rules. A second instance with a low
//   credit ceiling exercises coin refusal.
// ---------------------------------------------------------------------------
module tb_vend_fsm;
    import vend_pkg::*;

    localparam int TO_CYC = 100;
    localparam int MAX_CR = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [1:0] product_id;
    logic [7:0] price, credit, change;
    logic       dispense, change_valid, coin_reject, sold_out;
    logic [2:0] state_o;

    logic       cap_key_valid = 1'b0;
    logic [3:0] cap_key_code = 4'h0;
    logic [1:0] c_product_id;
    logic [7:0] c_price, c_credit, c_change;
    logic       c_dispense, c_change_valid, c_coin_reject, c_sold_out;
    logic [2:0] c_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    vend_fsm #(
        .N_PRODUCTS (4), .INIT_STOCK (5), .MAX_CREDIT (MAX_CR)
`ifdef VEND_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO_CYC)
`endif
    ) dut (
        .clk (clk), .reset (reset), .key_valid (key_valid), .key_code (key_code),
        .product_id (product_id), .price (price), .credit (credit), .change (change),
        .dispense (dispense), .change_valid (change_valid), .coin_reject (coin_reject),
        .sold_out (sold_out), .state_o (state_o)
    );

    vend_fsm #(
        .N_PRODUCTS (4), .INIT_STOCK (5), .MAX_CREDIT (20)
`ifdef VEND_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TO_CYC)
`endif
    ) dut_cap (
        .clk (clk), .reset (reset), .key_valid (cap_key_valid), .key_code (cap_key_code),
        .product_id (c_product_id), .price (c_price), .credit (c_credit), .change (c_change),
        .dispense (c_dispense), .change_valid (c_change_valid), .coin_reject (c_coin_reject),
        .sold_out (c_sold_out), .state_o (c_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_PAY = 1, P_DISP = 2, P_WAIT = 3, P_CHG = 4, P_SOLD = 5;
    int PRICES [4] = '{15, 20, 25, 40};
    int m_phase, m_credit, m_price, m_pid, m_change, m_idle;
    int m_stock [4];
    bit m_rej;

    function automatic int coin_val(input logic [3:0] c);
        case (c)
            4'hA:    return 2;
            4'hB:    return 5;
            4'hC:    return 10;
            default: return 0;
        endcase
    endfunction

    function automatic bit mapped(input logic [3:0] c);
        return (c >= 4'h1 && c <= 4'h4) || (c >= 4'hA && c <= 4'hE);
    endfunction

    function automatic logic [2:0] phase_code(input int ph);
        case (ph)
            P_IDLE:  return IDLE;
            P_PAY:   return PAY;
            P_DISP:  return DISPENSE;
            P_WAIT:  return WAIT_TAKE;
            P_CHG:   return CHANGE;
            default: return SOLDOUT;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int  cv;
        bit  kv, timed_out, ready;
        cv = coin_val(key_code);
        kv = key_valid && mapped(key_code);
        m_rej = 1'b0;
        timed_out = 1'b0;
        if (reset) begin
            m_phase = P_IDLE; m_credit = 0; m_price = 0; m_pid = 0; m_change = 0; m_idle = 0;
            for (int i = 0; i < 4; i++) m_stock[i] = 5;
        end else begin
`ifdef VEND_TIMEOUT_EN
            if (m_phase == P_PAY) begin
                if (kv) m_idle = 0;
                else begin
                    if (m_idle == TO_CYC - 1) timed_out = 1'b1;
                    m_idle++;
                end
            end else begin
                m_idle = 0;
            end
`endif
            case (m_phase)
                P_IDLE: begin
                    if (kv && key_code >= 4'h1 && key_code <= 4'h4) begin
                        if (m_stock[key_code - 1] == 0) m_phase = P_SOLD;
                        else begin
                            m_pid = key_code - 1; m_price = PRICES[m_pid];
                            m_credit = 0; m_phase = P_PAY;
                        end
                    end else if (kv && cv > 0) m_rej = 1'b1;
                end
                P_PAY: begin
                    ready = (m_credit >= m_price);
                    if (kv && cv > 0) begin
                        if (m_credit + cv <= MAX_CR) m_credit += cv;
                        else m_rej = 1'b1;
                    end
                    if (ready) m_phase = P_DISP;
                    else if ((kv && key_code == 4'hD) || timed_out) begin
                        m_change = m_credit; m_phase = P_CHG;
                    end
                end
                P_DISP: begin
                    if (m_stock[m_pid] > 0) m_stock[m_pid]--;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (kv && key_code == 4'hE) begin
                        m_change = m_credit - m_price; m_phase = P_CHG;
                    end else if (kv && cv > 0) m_rej = 1'b1;
                end
                P_CHG:   begin m_credit = 0; m_phase = P_IDLE; end
                default: if (kv) m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("cyc_state",        state_o,      phase_code(m_phase));
            check("cyc_product_id",   product_id,   m_pid);
            check("cyc_price",        price,        m_price);
            check("cyc_credit",       credit,       m_credit);
            check("cyc_change",       change,       m_change);
            check("cyc_dispense",     dispense,     m_phase == P_DISP);
            check("cyc_change_valid", change_valid, m_phase == P_CHG);
            check("cyc_coin_reject",  coin_reject,  m_rej);
            check("cyc_sold_out",     sold_out,     m_phase == P_SOLD);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic key_on(input logic [3:0] c);
        @(negedge clk); key_valid = 1'b1; key_code = c;
    endtask
    task automatic keys_off();
        @(negedge clk); key_valid = 1'b0; key_code = 4'h0;
    endtask
    task automatic press(input logic [3:0] c);
        key_on(c); keys_off();
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic cap_press(input logic [3:0] c);
        @(negedge clk); cap_key_valid = 1'b1; cap_key_code = c;
        @(negedge clk); cap_key_valid = 1'b0; cap_key_code = 4'h0;
    endtask

    logic [3:0] pool [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hC,
                              4'hC, 4'hB, 4'hD, 4'hE, 4'hE, 4'h0, 4'hF, 4'h5};

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_state", state_o, IDLE);
        check("rst_credit", credit, 0);
        check("rst_price", price, 0);
        check("rst_change", change, 0);
        check("rst_strobes", {dispense, change_valid, coin_reject, sold_out}, 0);
        cmp_en = 1'b1;

        // 1: product 1, coins 10 + 5, take, zero change
        press(4'h1);
        check("t1_state_pay", state_o, PAY);
        check("t1_price", price, 15);
        press(4'hC); check("t1_credit10", credit, 10);
        press(4'hB); check("t1_credit15", credit, 15);
        check("t1_no_disp_yet", dispense, 0);
        idle(1);     check("t1_dispense", dispense, 1);
        idle(1);     check("t1_wait_take", state_o, WAIT_TAKE);
        press(4'hE);
        check("t1_change_valid", change_valid, 1);
        check("t1_change", change, 0);
        idle(1);     check("t1_idle", state_o, IDLE);

        // 2: product 4, five back-to-back 10 coins, change 10
        press(4'h4); check("t2_price", price, 40);
        repeat (5) key_on(4'hC);
        keys_off();
        check("t2_credit50", credit, 50);
        check("t2_dispense", dispense, 1);
        check("pin_model_credit", m_credit, 50);
        idle(1);
        press(4'hE);
        check("t2_change", change, 10);
        check("t2_change_valid", change_valid, 1);
        idle(1);

        // 3: coin refusal at the ceiling (second instance, ceiling 20)
        press(4'hA);
        check("t3_idle_coin_reject", coin_reject, 1);
        cap_press(4'h4); check("t3_cap_price", c_price, 40);
        cap_press(4'hC);
        cap_press(4'hC); check("t3_cap_at_ceiling", c_credit, 20);
        cap_press(4'hA);
        check("t3_cap_reject", c_coin_reject, 1);
        check("t3_cap_credit_kept", c_credit, 20);
        idle(1);         check("t3_cap_reject_pulse", c_coin_reject, 0);
        cap_press(4'hD);
        check("t3_cap_change", c_change, 20);
        check("t3_cap_change_valid", c_change_valid, 1);
        idle(1);         check("t3_cap_idle", c_state, IDLE);

        // 4: product 2, coin 2, cancel
        press(4'h2);
        press(4'hA); check("t4_credit", credit, 2);
        press(4'hD);
        check("t4_state_change", state_o, CHANGE);
        check("t4_change", change, 2);
        check("t4_no_dispense", dispense, 0);
        idle(1);
        check("t4_idle", state_o, IDLE);
        check("t4_credit_cleared", credit, 0);

        // 5: drain product 3, then sold out
        for (int v = 0; v < 5; v++) begin
            press(4'h3); press(4'hC); press(4'hC); press(4'hB);
            idle(1); check("t5_dispense", dispense, 1);
            idle(1); press(4'hE);
            check("t5_change", change, 0);
            idle(1);
        end
        check("pin_model_stock3", m_stock[2], 0);
        press(4'h3);
        check("t5_soldout_state", state_o, SOLDOUT);
        check("t5_sold_out", sold_out, 1);
        press(4'hA);
        check("t5_back_idle", state_o, IDLE);
        check("t5_coin_consumed", coin_reject, 0);

        // 6: reset in PAY with credit 10
        press(4'h1); press(4'hC);
        check("t6_credit10", credit, 10);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("t6_state_idle", state_o, IDLE);
        check("t6_credit0", credit, 0);
        check("t6_no_change_valid", change_valid, 0);
        press(4'h3);
        check("t6_stock_restored", state_o, PAY);
        press(4'hD);
        check("t6_cancel_change", change, 0);
        idle(1);

`ifdef VEND_TIMEOUT_EN
        press(4'h1); press(4'hB);
        idle(TO_CYC - 1); check("to_still_pay", state_o, PAY);
        idle(1);
        check("to_state_change", state_o, CHANGE);
        check("to_change", change, 5);
        idle(1);
`endif

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 399) == 0);
            key_valid = ($urandom_range(0, 99) < 45);
            key_code  = pool[$urandom_range(0, 15)];
        end
        @(negedge clk); reset = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
